// File: rtl/decode_nw.sv
// decode_nw: N-wide RV32 decoder feeding a DEPTH-entry bundle queue.
// Define DECODE_NW_ILLEGAL_CHK_EN to flag unknown opcodes and drop younger lanes.
package decode_nw_pkg;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } t_rv_instr;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_REG,
    OP_IMM
  } t_otype;

  typedef struct packed {
    logic [4:0] idx;
    t_otype     otype;
  } t_opnd;

  typedef struct packed {
    logic [6:0]  opcode;
    t_opnd       dst;
    t_opnd       src1;
    t_opnd       src2;
    logic [31:0] imm;
    logic        illegal;
  } t_uinstr;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_X
  } t_fmt;

  function automatic t_fmt get_instr_format(
    input logic [6:0] op
  );
    t_fmt f;
    unique case (op)
      7'h33, 7'h3B: f = FMT_R;
      7'h13, 7'h03, 7'h67,
      7'h1B, 7'h73, 7'h0F: f = FMT_I;
      7'h23: f = FMT_S;
      7'h63: f = FMT_B;
      7'h37, 7'h17: f = FMT_U;
      7'h6F: f = FMT_J;
      default: f = FMT_X;
    endcase
    return f;
  endfunction

  function automatic t_uinstr decode_lane(
    input t_rv_instr ins
  );
    t_uinstr     u;
    t_fmt        fmt;
    logic [31:0] w;
    w = ins;
    fmt = get_instr_format(ins.opcode);
    u = '0;
    u.opcode = ins.opcode;
    unique case (1'b1)
      (fmt == FMT_R): begin
        u.dst  = '{ins.rd, OP_REG};
        u.src1 = '{ins.rs1, OP_REG};
        u.src2 = '{ins.rs2, OP_REG};
      end
      (fmt == FMT_I): begin
        u.dst  = '{ins.rd, OP_REG};
        u.src1 = '{ins.rs1, OP_REG};
        u.src2.otype = OP_IMM;
        u.imm  = {{20{w[31]}}, w[31:20]};
      end
      (fmt == FMT_S): begin
        u.src1 = '{ins.rs1, OP_REG};
        u.src2 = '{ins.rs2, OP_REG};
        u.imm  = {{20{w[31]}}, w[31:25], w[11:7]};
      end
      (fmt == FMT_B): begin
        u.src1 = '{ins.rs1, OP_REG};
        u.src2 = '{ins.rs2, OP_REG};
        u.imm  = {{19{w[31]}}, w[31], w[7],
                  w[30:25], w[11:8], 1'b0};
      end
      (fmt == FMT_U): begin
        u.dst  = '{ins.rd, OP_REG};
        u.src1.otype = OP_IMM;
        u.imm  = {w[31:12], 12'b0};
      end
      (fmt == FMT_J): begin
        u.dst  = '{ins.rd, OP_REG};
        u.imm  = {{11{w[31]}}, w[31], w[19:12],
                  w[20], w[30:21], 1'b0};
      end
      default: ;
    endcase
    // writes to x0 are discarded, so there is no real destination
    if (u.dst.otype == OP_REG && u.dst.idx == 5'd0)
      u.dst.otype = OP_NONE;
    return u;
  endfunction

endpackage

module decode_nw
  import decode_nw_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_LANES-1:0]            valid_de0,
  input  t_rv_instr [NUM_LANES-1:0]       instr_de0,
  output logic                            ready_de0,
  output logic [NUM_LANES-1:0]            valid_de1,
  output t_uinstr [NUM_LANES-1:0]         uinstr_de1,
  input  logic                            ready_de1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [NUM_LANES-1:0]    dec_v;
  t_uinstr [NUM_LANES-1:0] dec_u;

  logic [NUM_LANES-1:0]    mem_v_q [DEPTH];
  logic [NUM_LANES-1:0]    mem_v_d [DEPTH];
  t_uinstr [NUM_LANES-1:0] mem_u_q [DEPTH];
  t_uinstr [NUM_LANES-1:0] mem_u_d [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic empty;
  logic push;
  logic pop;

`ifdef DECODE_NW_ILLEGAL_CHK_EN
  logic cut;

  always_comb begin
    dec_v = '0;
    dec_u = '0;
    cut   = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (valid_de0[l] && !cut) begin
        dec_v[l] = 1'b1;
        dec_u[l] = decode_lane(instr_de0[l]);
        if (get_instr_format(instr_de0[l].opcode) == FMT_X) begin
          dec_u[l].illegal = 1'b1;
          cut = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    dec_v = '0;
    dec_u = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (valid_de0[l]) begin
        dec_v[l] = 1'b1;
        dec_u[l] = decode_lane(instr_de0[l]);
      end
    end
  end
`endif

  assign empty     = (cnt_q == '0);
  assign ready_de0 = ~reset & (cnt_q != CW'(DEPTH));
  assign valid_de1 = empty ? '0 : mem_v_q[rd_ptr_q];
  assign uinstr_de1 = empty ? '0 : mem_u_q[rd_ptr_q];

  assign push = ready_de0 & (|valid_de0);
  assign pop  = (|valid_de1) & ready_de1;

  always_comb begin
    mem_v_d  = mem_v_q;
    mem_u_d  = mem_u_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_v_d[wr_ptr_q] = dec_v;
      mem_u_d[wr_ptr_q] = dec_u;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // storage is masked by the empty flag, so it needs no reset
  always_ff @(posedge clk) begin
    mem_v_q <= mem_v_d;
    mem_u_q <= mem_u_d;
  end

endmodule

// File: tb/tb_decode_nw.sv
// tb_decode_nw: vector table plus scoreboard bench for decode_nw.
// Honours DECODE_NW_ILLEGAL_CHK_EN when building expectations.
module tb_decode_nw;
  import decode_nw_pkg::*;

  localparam int NL = 2;
  localparam int D  = 4;
  localparam int NV = 10;

`ifdef DECODE_NW_ILLEGAL_CHK_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif

  typedef struct packed {
    logic [NL-1:0]    v;
    t_uinstr [NL-1:0] u;
  } bundle_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    t_uinstr     exp;
  } vec_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NL-1:0]       valid_de0 = '0;
  t_rv_instr [NL-1:0]  instr_de0 = '0;
  logic                ready_de0;
  logic [NL-1:0]       valid_de1;
  t_uinstr [NL-1:0]    uinstr_de1;
  logic                ready_de1 = 1'b0;

  bundle_t cur_exp = '0;
  bundle_t sb[$];
  vec_t    vecs[NV];
  int      n_pass = 0;
  int      n_total = 0;
  bit      do_pop, do_push;

  always #5 clk = ~clk;

  decode_nw #(.NUM_LANES(NL), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_de0 (valid_de0),
    .instr_de0 (instr_de0),
    .ready_de0 (ready_de0),
    .valid_de1 (valid_de1),
    .uinstr_de1(uinstr_de1),
    .ready_de1 (ready_de1)
  );

  task automatic check(string nm, logic [127:0] act,
                       logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
  endtask

  function automatic t_uinstr mk(
    logic [6:0] op,
    logic [4:0] d, t_otype dt,
    logic [4:0] s1, t_otype s1t,
    logic [4:0] s2, t_otype s2t,
    logic [31:0] imm, logic ill
  );
    t_uinstr u;
    u.opcode  = op;
    u.dst     = '{d, dt};
    u.src1    = '{s1, s1t};
    u.src2    = '{s2, s2t};
    u.imm     = imm;
    u.illegal = ill;
    return u;
  endfunction

  function automatic bundle_t b1(t_uinstr u0);
    bundle_t b;
    b = '0;
    b.v = 2'b01;
    b.u[0] = u0;
    return b;
  endfunction

  // an illegal older lane squashes the younger one
  function automatic bundle_t b2(t_uinstr u0, t_uinstr u1);
    bundle_t b;
    b = '0;
    b.u[0] = u0;
    if (u0.illegal) begin
      b.v = 2'b01;
    end else begin
      b.v = 2'b11;
      b.u[1] = u1;
    end
    return b;
  endfunction

  // reference queue model
  always @(posedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      do_pop  = (sb.size() > 0) && ready_de1;
      do_push = (sb.size() < D) && (|valid_de0);
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(cur_exp);
    end
  end

  always @(negedge clk) begin
    check("ready_de0", 128'(ready_de0),
          128'(!reset && sb.size() < D));
    if (sb.size() > 0)
      check("head", 128'({valid_de1, uinstr_de1}),
            128'(sb[0]));
    else
      check("idle", 128'({valid_de1, uinstr_de1}),
            128'(0));
  end

  task automatic drive(logic [NL-1:0] v, logic [31:0] i0,
                       logic [31:0] i1, bundle_t e, logic rdy);
    @(posedge clk);
    #1;
    valid_de0    = v;
    instr_de0[0] = i0;
    instr_de0[1] = i1;
    cur_exp      = e;
    ready_de1    = rdy;
  endtask

  task automatic idle(logic rdy, int n);
    for (int k = 0; k < n; k++)
      drive('0, 32'h0, 32'h0, '0, rdy);
  endtask

  initial begin
    vecs[0] = '{"add", 32'h002081B3,
      mk(7'h33, 5'd3, OP_REG, 5'd1, OP_REG, 5'd2, OP_REG,
         32'h0, 1'b0)};
    vecs[1] = '{"addi", 32'hFFF00293,
      mk(7'h13, 5'd5, OP_REG, 5'd0, OP_REG, 5'd0, OP_IMM,
         32'hFFFF_FFFF, 1'b0)};
    vecs[2] = '{"lui", 32'h123453B7,
      mk(7'h37, 5'd7, OP_REG, 5'd0, OP_IMM, 5'd0, OP_NONE,
         32'h1234_5000, 1'b0)};
    vecs[3] = '{"sw", 32'h0020A423,
      mk(7'h23, 5'd0, OP_NONE, 5'd1, OP_REG, 5'd2, OP_REG,
         32'h8, 1'b0)};
    vecs[4] = '{"beq", 32'hFE208EE3,
      mk(7'h63, 5'd0, OP_NONE, 5'd1, OP_REG, 5'd2, OP_REG,
         32'hFFFF_FFFC, 1'b0)};
    vecs[5] = '{"jal", 32'h001000EF,
      mk(7'h6F, 5'd1, OP_REG, 5'd0, OP_NONE, 5'd0, OP_NONE,
         32'h800, 1'b0)};
    vecs[6] = '{"add_x0", 32'h00208033,
      mk(7'h33, 5'd0, OP_NONE, 5'd1, OP_REG, 5'd2, OP_REG,
         32'h0, 1'b0)};
    vecs[7] = '{"unknown", 32'hDEADBEFF,
      mk(7'h7F, 5'd0, OP_NONE, 5'd0, OP_NONE, 5'd0, OP_NONE,
         32'h0, ILL)};
    vecs[8] = '{"lw", 32'hFF812203,
      mk(7'h03, 5'd4, OP_REG, 5'd2, OP_REG, 5'd0, OP_IMM,
         32'hFFFF_FFF8, 1'b0)};
    vecs[9] = '{"auipc", 32'hFFFFF497,
      mk(7'h17, 5'd9, OP_REG, 5'd0, OP_IMM, 5'd0, OP_NONE,
         32'hFFFF_F000, 1'b0)};

    // bundle offered while in reset must vanish
    drive(2'b01, vecs[0].instr, 32'h0, b1(vecs[0].exp), 1'b1);
    drive(2'b11, vecs[1].instr, vecs[2].instr, '0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    valid_de0 = '0;
    cur_exp = '0;
    idle(1'b1, 2);

    for (int i = 0; i < NV; i++) begin
      drive(2'b01, vecs[i].instr, 32'h0, b1(vecs[i].exp), 1'b1);
      idle(1'b1, 1);
    end

    for (int i = 0; i < NV; i++) begin
      drive(2'b11, vecs[i].instr, vecs[(i + 1) % NV].instr,
            b2(vecs[i].exp, vecs[(i + 1) % NV].exp), 1'b1);
      idle(1'b1, 1);
    end

    drive(2'b11, vecs[0].instr, 32'h0000007F,
          b2(vecs[0].exp,
             mk(7'h7F, 5'd0, OP_NONE, 5'd0, OP_NONE, 5'd0,
                OP_NONE, 32'h0, ILL)), 1'b1);
    idle(1'b1, 2);

    // fill to DEPTH, fifth offer must be dropped
    for (int k = 0; k <= D; k++)
      drive(2'b01, vecs[k].instr, 32'h0, b1(vecs[k].exp), 1'b0);
    idle(1'b1, D + 2);

    // streaming at occupancy DEPTH-1
    for (int k = 0; k < D - 1; k++)
      drive(2'b01, vecs[k].instr, 32'h0, b1(vecs[k].exp), 1'b0);
    for (int k = 0; k < 6; k++)
      drive(2'b11, vecs[k + 2].instr, vecs[k].instr,
            b2(vecs[k + 2].exp, vecs[k].exp), 1'b1);
    idle(1'b1, D + 2);

    // streaming at occupancy 1, pointers wrap twice
    drive(2'b01, vecs[9].instr, 32'h0, b1(vecs[9].exp), 1'b0);
    for (int k = 0; k < 2 * D; k++)
      drive(2'b01, vecs[k].instr, 32'h0, b1(vecs[k].exp), 1'b1);
    idle(1'b1, 3);

    // reset with three bundles queued
    for (int k = 0; k < 3; k++)
      drive(2'b01, vecs[k + 3].instr, 32'h0,
            b1(vecs[k + 3].exp), 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    valid_de0 = 2'b01;
    instr_de0[0] = vecs[1].instr;
    cur_exp = '0;
    idle(1'b0, 1);
    valid_de0 = 2'b01;
    @(posedge clk);
    #1;
    reset = 1'b0;
    valid_de0 = '0;
    ready_de1 = 1'b1;
    idle(1'b1, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_nw.md
DECODE_NW -- requirements
Module: decode_nw

Interface
REQ-001 SHALL have parameter NUM_LANES, default 2, number of instructions decoded per bundle (1..4).
REQ-002 SHALL have parameter DEPTH, default 4, number of decoded bundles held in the output queue (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port valid_de0  input  NUM_LANES  per-lane instruction valid; contiguous from lane 0.
REQ-006 SHALL have port instr_de0  input  NUM_LANES x t_rv_instr  raw 32-bit instructions.
REQ-007 SHALL have port ready_de0  output  1  decoder can accept a bundle this cycle.
REQ-008 SHALL have port valid_de1  output  NUM_LANES  per-lane decoded uop valid at queue head.
REQ-009 SHALL have port uinstr_de1  output  NUM_LANES x t_uinstr  decoded uops at queue head.
REQ-010 SHALL have port ready_de1  input  1  consumer takes the head bundle this cycle.

Function
REQ-011 Bundle SHALL be accepted when ready_de0 && |valid_de0; lanes with valid_de0=0 are stored as invalid with uinstr='0.
REQ-012 ready_de0 SHALL be 1 iff queue occupancy < DEPTH, computed from registered state only (no combinational path from ready_de1).
REQ-013 Each lane SHALL decode independently: format = get_instr_format(opcode); uinstr.opcode = instr.opcode; all other fields default '0.
REQ-014 R format: dst=rd/OP_REG, src1=rs1/OP_REG, src2=rs2/OP_REG.
REQ-015 I format: dst=rd/OP_REG, src1=rs1/OP_REG, src2 otype=OP_IMM, imm = sign-extended instr[31:20].
REQ-016 S and B formats: src1=rs1/OP_REG, src2=rs2/OP_REG, dst otype=OP_NONE; imm = sign-extended S or B immediate (B immediate bit 0 = 0).
REQ-017 U format: dst=rd/OP_REG, src1 otype=OP_IMM, imm = {instr[31:12],12'b0}; J format: dst=rd/OP_REG, imm = sign-extended J immediate (bit 0 = 0).
REQ-018 Any rd, rs1 or rs2 field equal to x0 as a destination SHALL yield dst otype=OP_NONE.
REQ-019 Decode-to-output latency SHALL be exactly 1 cycle when the queue is empty: bundle accepted at edge N is visible on valid_de1/uinstr_de1 after edge N.
REQ-020 Head bundle SHALL be popped when |valid_de1 && ready_de1; valid_de1 SHALL be all-zero when empty and uinstr_de1 SHALL then be '0.
REQ-021 Queue SHALL be strict FIFO; read/write pointers wrap modulo DEPTH without loss or duplication.
REQ-022 Simultaneous push and pop SHALL keep occupancy unchanged, including at occupancy 1 (new bundle becomes head the next cycle) and occupancy DEPTH-1.
REQ-023 When full, ready_de0=0 and an offered bundle SHALL be ignored; a pop in that cycle SHALL raise ready_de0 the following cycle.
REQ-024 Outputs SHALL hold stable while valid and ready_de1=0.

Reset
REQ-025 While reset=1: occupancy=0, pointers=0, valid_de1='0, uinstr_de1='0, ready_de0=0; inputs ignored.
REQ-026 First cycle after reset deassertion: ready_de0=1; a bundle offered mid-reset SHALL never appear at the output.

Configuration
REQ-027 Macro DECODE_NW_ILLEGAL_CHK_EN: when defined, an opcode whose format is not R/I/S/B/U/J SHALL set uinstr.illegal=1 with all operand otypes OP_NONE, and only the lowest illegal lane plus lanes below it stay valid (younger lanes of that bundle are dropped, valid=0).
REQ-028 Without DECODE_NW_ILLEGAL_CHK_EN: unknown formats SHALL decode as opcode-only uops with illegal=0, and all valid lanes SHALL be kept.

Verification
REQ-029 Single R instr add x3,x1,x2 on lane 0 with empty queue, ready_de1=1 -> next cycle valid_de1=2'b01, dst=3/REG, src1=1/REG, src2=2/REG; queue empty one cycle later.
REQ-030 I instr addi x5,x0,-1 -> src2 otype=OP_IMM, imm=32'hFFFF_FFFF; lui x7,0x12345 -> imm=32'h1234_5000.
REQ-031 ready_de1=0, push DEPTH bundles back-to-back -> ready_de0 falls after 4th accept; 5th offer dropped; raise ready_de1 -> bundles emerge in order, one per cycle, ready_de0 high next cycle.
REQ-032 Occupancy 1 with simultaneous push and pop for 2*DEPTH cycles -> output sequence identical to input sequence, pointers wrap twice, no gaps.
REQ-033 Assert reset with 3 bundles queued -> next cycle valid_de1=0, ready_de0=0; after release ready_de0=1, no stale bundle appears.
REQ-034 With DECODE_NW_ILLEGAL_CHK_EN, bundle {lane0 valid R, lane1 opcode 7'h7F} -> valid_de1=2'b11, lane1 illegal=1; without macro -> lane1 illegal=0, opcode=7'h7F.
